// File: rtl/ifft_frame_capture.sv
`default_nettype none
// ============================================================================
//  Module      : ifft_frame_capture
//  Description : Decimates the IFFT I/Q stream, waits for a rising crossing
//                of a programmable level (or a timeout), and freezes a
//                DEPTH-sample frame with PRE samples of pre-trigger history.
//                The frame is read through a registered port where logical
//                address 0 is the oldest stored sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifft_frame_capture #(
    parameter int DEPTH   = 64,
    parameter int AW      = 6,
    parameter int DECIM   = 31,
    parameter int PRE     = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                CLOCK_50,
    input  logic                KEY,
    input  logic signed [7:0]   ifft_Iout,
    input  logic signed [7:0]   ifft_Qout,
    input  logic                ifft_valid,
    input  logic                ch_sel,
    input  logic signed [7:0]   trig_level,
    input  logic                arm,
    input  logic [AW-1:0]       rd_addr,
    output logic signed [7:0]   rd_data,
    output logic                frame_ready,
    output logic                busy,
    output logic                timed_out
);

    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [DCW-1:0] c_dec_last  = DCW'(DECIM - 1);
    localparam logic [AW-1:0]  c_pre       = AW'(PRE);
    localparam logic [AW-1:0]  c_pre_last  = AW'(PRE - 1);
    localparam logic [AW-1:0]  c_post_last = AW'(DEPTH - PRE - 2);
    localparam logic [TW-1:0]  c_to_last   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [DCW-1:0]         dcnt_q, dcnt_d;
    logic [AW-1:0]          wp_q, wp_d;
    logic [AW-1:0]          cnt_q, cnt_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [AW-1:0]          trig_ptr_q, trig_ptr_d;
    logic signed [7:0]      prev_q, prev_d;
    logic signed [7:0]      rd_data_q, rd_data_d;
    logic                   frame_ready_q, frame_ready_d;
    logic                   busy_q, busy_d;
    logic                   timed_out_q, timed_out_d;

    logic                   tick;
    logic signed [7:0]      sample;
    logic                   crossing;
    logic                   mem_we;
    logic [AW-1:0]          rd_phys;

    logic signed [7:0]      mem [DEPTH];

    // Decimator, channel select, previous-sample tracking and trigger detect
    always_comb begin
        tick     = ifft_valid && (dcnt_q == c_dec_last);
        dcnt_d   = dcnt_q;
        if (ifft_valid) begin
            dcnt_d = tick ? '0 : dcnt_q + DCW'(1);
        end
        sample   = ch_sel ? ifft_Qout : ifft_Iout;
        prev_d   = tick ? sample : prev_q;
        crossing = (prev_q < trig_level) && (sample >= trig_level);
    end

    // Capture FSM next-state, pointer/counter updates and status flags
    always_comb begin
        state_d       = state_q;
        wp_d          = wp_q;
        cnt_d         = cnt_q;
        tcnt_d        = tcnt_q;
        trig_ptr_d    = trig_ptr_q;
        timed_out_d   = timed_out_q;
        busy_d        = busy_q;
        frame_ready_d = frame_ready_q;
        mem_we        = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d       = S_PRE;
                    wp_d          = '0;
                    cnt_d         = '0;
                    tcnt_d        = '0;
                    timed_out_d   = 1'b0;
                    busy_d        = 1'b1;
                    frame_ready_d = 1'b0;
                end
            end
            S_PRE: begin
                if (tick) begin
                    mem_we = 1'b1;
                    wp_d   = wp_q + AW'(1);
                    cnt_d  = cnt_q + AW'(1);
                    if (cnt_q == c_pre_last) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (tick) begin
                    mem_we = 1'b1;
                    wp_d   = wp_q + AW'(1);
                    // A genuine crossing takes priority over the timeout
                    if (crossing || (tcnt_q == c_to_last)) begin
                        trig_ptr_d  = wp_q;
                        cnt_d       = '0;
                        state_d     = S_POST;
                        timed_out_d = !crossing;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            S_POST: begin
                if (tick) begin
                    mem_we = 1'b1;
                    wp_d   = wp_q + AW'(1);
                    cnt_d  = cnt_q + AW'(1);
                    if (cnt_q == c_post_last) begin
                        state_d       = S_DONE;
                        busy_d        = 1'b0;
                        frame_ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Logical-to-physical read mapping: trigger sample lands at logical PRE
    always_comb begin
        rd_phys   = trig_ptr_q - c_pre + rd_addr;
        rd_data_d = mem[rd_phys];
    end

    // Frame buffer write port; contents survive reset
    always_ff @(posedge CLOCK_50) begin
        if (mem_we) begin
            mem[wp_q] <= sample;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state_q       <= S_IDLE;
            dcnt_q        <= '0;
            wp_q          <= '0;
            cnt_q         <= '0;
            tcnt_q        <= '0;
            trig_ptr_q    <= '0;
            prev_q        <= '0;
            rd_data_q     <= '0;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            timed_out_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            dcnt_q        <= dcnt_d;
            wp_q          <= wp_d;
            cnt_q         <= cnt_d;
            tcnt_q        <= tcnt_d;
            trig_ptr_q    <= trig_ptr_d;
            prev_q        <= prev_d;
            rd_data_q     <= rd_data_d;
            frame_ready_q <= frame_ready_d;
            busy_q        <= busy_d;
            timed_out_q   <= timed_out_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_ready = frame_ready_q;
    assign busy        = busy_q;
    assign timed_out   = timed_out_q;

endmodule
`default_nettype wire

// File: tb/tb_ifft_frame_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifft_frame_capture
//  Description : Directed self-checking bench for ifft_frame_capture. dut_a
//                runs undecimated with a short timeout; dut_b runs with the
//                default decimation. Both share the stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifft_frame_capture;

    logic               CLOCK_50 = 1'b0;
    logic               KEY;
    logic signed [7:0]  ifft_Iout;
    logic signed [7:0]  ifft_Qout;
    logic               ifft_valid;
    logic               ch_sel;
    logic signed [7:0]  trig_level;
    logic               arm;
    logic [5:0]         rd_addr;

    logic signed [7:0]  rd_data_a, rd_data_b;
    logic               frame_ready_a, frame_ready_b;
    logic               busy_a, busy_b;
    logic               timed_out_a, timed_out_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    ifft_frame_capture #(
        .DEPTH(64), .AW(6), .DECIM(1), .PRE(16), .TIMEOUT(100)
    ) dut_a (
        .CLOCK_50(CLOCK_50), .KEY(KEY),
        .ifft_Iout(ifft_Iout), .ifft_Qout(ifft_Qout), .ifft_valid(ifft_valid),
        .ch_sel(ch_sel), .trig_level(trig_level), .arm(arm), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .frame_ready(frame_ready_a), .busy(busy_a),
        .timed_out(timed_out_a)
    );

    ifft_frame_capture #(
        .DEPTH(64), .AW(6), .DECIM(31), .PRE(16), .TIMEOUT(4096)
    ) dut_b (
        .CLOCK_50(CLOCK_50), .KEY(KEY),
        .ifft_Iout(ifft_Iout), .ifft_Qout(ifft_Qout), .ifft_valid(ifft_valid),
        .ch_sel(ch_sel), .trig_level(trig_level), .arm(arm), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .frame_ready(frame_ready_b), .busy(busy_b),
        .timed_out(timed_out_b)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        KEY        = 1'b0;
        arm        = 1'b0;
        ifft_valid = 1'b0;
        repeat (2) step();
        KEY = 1'b1;
    endtask

    // Q/I ramp one step per cycle; arm asserted on the cycle carrying arm_v
    task automatic run_ramp(input int start_v, input int arm_v, input int stop_v,
                            output int last_v, output int ncyc);
        int v;
        v          = start_v;
        ncyc       = 0;
        last_v     = start_v;
        ifft_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            ifft_Qout = 8'(v);
            ifft_Iout = 8'(v);
            arm       = (v == arm_v);
            step();
            ncyc++;
            last_v = v;
            if (frame_ready_a || v == stop_v) break;
            v++;
        end
        arm = 1'b0;
    endtask

    // Q held at -5, switching to 0 from cycle switch_i onward; arm on cycle 0
    task automatic run_hold(input int switch_i, output int ncyc);
        ncyc       = 0;
        ifft_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            ifft_Qout = (i >= switch_i) ? 8'sd0 : -8'sd5;
            arm       = (i == 0);
            step();
            ncyc++;
            if (frame_ready_a) break;
        end
        arm = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input bit use_b, input int addr, input int exp);
        rd_addr = 6'(addr);
        step();
        check_eq(tag, use_b ? int'(rd_data_b) : int'(rd_data_a), exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lv, n, k, last_k, bad;
        logic [7:0] vals [64];
        logic [7:0] d;

        ch_sel     = 1'b1;
        trig_level = 8'sd0;
        rd_addr    = '0;
        ifft_Iout  = '0;
        ifft_Qout  = '0;
        ifft_valid = 1'b0;
        arm        = 1'b0;
        KEY        = 1'b0;
        repeat (2) step();
        check_eq("rst_rd_data", int'(rd_data_a), 0);
        check_eq("rst_frame_ready", frame_ready_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_timed_out", timed_out_a, 0);
        check_eq("rst_busy_b", busy_b, 0);
        KEY = 1'b1;

        // Ramp from -64, trigger on the -1 -> 0 crossing
        run_ramp(-64, -64, 1000, lv, n);
        check_eq("ramp_ready", frame_ready_a, 1);
        check_eq("ramp_last_sample", lv, 47);
        check_eq("ramp_cycles", n, 112);
        check_eq("ramp_timed_out", timed_out_a, 0);
        check_eq("ramp_busy_done", busy_a, 0);
        rd_chk("ramp_rd0", 0, 0, -16);
        rd_chk("ramp_rd15", 0, 15, -1);
        rd_chk("ramp_rd16", 0, 16, 0);
        rd_chk("ramp_rd17", 0, 17, 1);
        rd_chk("ramp_rd63", 0, 63, 47);

        // Ramp from -120 armed late: write pointer wraps before the trigger
        do_reset();
        run_ramp(-120, -100, 1000, lv, n);
        check_eq("wrap_ready", frame_ready_a, 1);
        check_eq("wrap_last_sample", lv, 47);
        check_eq("wrap_cycles", n, 168);
        check_eq("wrap_timed_out", timed_out_a, 0);
        rd_chk("wrap_rd0", 0, 0, -16);
        rd_chk("wrap_rd16", 0, 16, 0);
        rd_chk("wrap_rd63", 0, 63, 47);

        // Constant level never crosses: forced trigger after 100 WAIT ticks
        do_reset();
        run_hold(1000, n);
        check_eq("to_ready", frame_ready_a, 1);
        check_eq("to_cycles", n, 164);
        check_eq("to_timed_out", timed_out_a, 1);
        rd_chk("to_rd0", 0, 0, -5);
        rd_chk("to_rd16", 0, 16, -5);
        rd_chk("to_rd40", 0, 40, -5);
        rd_chk("to_rd63", 0, 63, -5);

        // Crossing on the very tick the timeout expires: crossing wins
        do_reset();
        run_hold(116, n);
        check_eq("tie_ready", frame_ready_a, 1);
        check_eq("tie_cycles", n, 164);
        check_eq("tie_timed_out", timed_out_a, 0);
        rd_chk("tie_rd15", 0, 15, -5);
        rd_chk("tie_rd16", 0, 16, 0);
        rd_chk("tie_rd63", 0, 63, 0);

        // Decimation by 31 with a 10-cycle valid gap in the middle
        do_reset();
        ch_sel     = 1'b0;
        trig_level = 8'sd50;
        k          = 0;
        last_k     = -1;
        for (int j = 0; j < 5000; j++) begin
            ifft_valid = !(j >= 1000 && j < 1010);
            ifft_Iout  = 8'(k);
            arm        = (j == 0);
            step();
            if (ifft_valid) begin
                last_k = k;
                k++;
            end
            if (frame_ready_b) break;
        end
        arm = 1'b0;
        check_eq("dec_ready", frame_ready_b, 1);
        check_eq("dec_last_k", last_k, 2045);
        check_eq("dec_timed_out", timed_out_b, 0);
        for (int a = 0; a < 64; a++) begin
            rd_addr = 6'(a);
            step();
            vals[a] = rd_data_b;
        end
        bad = 0;
        for (int a = 0; a < 63; a++) begin
            d = vals[a+1] - vals[a];
            if (d != 8'd31) bad++;
        end
        check_eq("dec_bad_steps", bad, 0);
        check_eq("dec_rd0", int'($signed(vals[0])), 92);
        check_eq("dec_rd16", int'($signed(vals[16])), 76);
        check_eq("dec_rd63", int'($signed(vals[63])), -3);

        // Asynchronous reset during POST, then no capture without arm
        do_reset();
        ch_sel     = 1'b1;
        trig_level = 8'sd0;
        run_ramp(-64, -64, 20, lv, n);
        check_eq("rst_pre_busy", busy_a, 1);
        #2;
        KEY = 1'b0;
        #1;
        check_eq("rst_async_busy", busy_a, 0);
        check_eq("rst_async_ready", frame_ready_a, 0);
        step();
        step();
        KEY = 1'b1;
        run_ramp(-64, 1000, 40, lv, n);
        check_eq("noarm_ready", frame_ready_a, 0);
        check_eq("noarm_busy", busy_a, 0);
        run_ramp(-64, -64, 1000, lv, n);
        check_eq("rearm_ready", frame_ready_a, 1);
        check_eq("rearm_last_sample", lv, 47);
        rd_chk("rearm_rd16", 0, 16, 0);

        // arm held in DONE restarts immediately
        arm = 1'b1;
        step();
        arm = 1'b0;
        check_eq("done_arm_ready", frame_ready_a, 0);
        check_eq("done_arm_busy", busy_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
